// File: rtl/booth_4_bit_multiplier.sv
// Iterative radix-2 Booth multiplier: signed 4-bit x signed 4-bit -> signed 8-bit.
// Runs one add/subtract-and-shift step per clock, with a start/busy/done handshake.
//
// state | meaning
// IDLE  | waiting for start; result holds the last product
// RUN   | four Booth iterations in progress
module booth_4_bit_multiplier (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [3:0] M,
   input  logic [3:0] Q,
   output logic       busy,
   output logic       done,
   output logic [7:0] result
);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t     state;
   logic [4:0] acc;
   logic [4:0] mcand;
   logic [3:0] qr;
   logic       q_1;
   logic [2:0] cnt;

   logic [4:0] acc_next;
   logic [9:0] shifted;

   // A is one bit wider than the operands so that M = -8 cannot overflow
   always_comb begin
      acc_next = acc;
      case ({qr[0], q_1})
         2'b01:   acc_next = acc + mcand;
         2'b10:   acc_next = acc - mcand;
         default: acc_next = acc;
      endcase
      shifted = {acc_next[4], acc_next, qr};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         acc    <= '0;
         mcand  <= '0;
         qr     <= '0;
         q_1    <= 1'b0;
         cnt    <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
         result <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  acc   <= '0;
                  mcand <= {M[3], M};
                  qr    <= Q;
                  q_1   <= 1'b0;
                  cnt   <= 3'd4;
                  busy  <= 1'b1;
                  state <= RUN;
               end
            end
            RUN: begin
               acc <= shifted[9:5];
               qr  <= shifted[4:1];
               q_1 <= shifted[0];
               cnt <= cnt - 3'd1;
               if (cnt == 3'd1) begin
                  result <= shifted[8:1];
                  done   <= 1'b1;
                  busy   <= 1'b0;
                  state  <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_booth_4_bit_multiplier.sv
// Self-checking bench for booth_4_bit_multiplier: expected products are queued at
// issue time and popped when done pulses.
module tb_booth_4_bit_multiplier;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       start = 1'b0;
   logic [3:0] m = '0;
   logic [3:0] q = '0;
   logic       busy;
   logic       done;
   logic [7:0] result;

   int total = 0;
   int bad = 0;
   logic [7:0] sb[$];

   booth_4_bit_multiplier dut (
      .clk(clk),
      .rst(rst),
      .start(start),
      .M(m),
      .Q(q),
      .busy(busy),
      .done(done),
      .result(result)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] prod(input logic [3:0] a, input logic [3:0] b);
      int p;
      p = int'($signed(a)) * int'($signed(b));
      return p[7:0];
   endfunction

   // Issues one operation from a negedge; returns at the negedge where done is seen.
   // lat counts negedges after the accept edge (5 means done after 4 RUN edges); -1 on timeout.
   task automatic run_op(input logic [3:0] a, input logic [3:0] b, input bit scramble,
                         output int lat, output int busy_cnt, output int done_cnt);
      start = 1'b1;
      m = a;
      q = b;
      sb.push_back(prod(a, b));
      @(posedge clk);
      #1;
      start = 1'b0;
      lat = -1;
      busy_cnt = 0;
      done_cnt = 0;
      for (int i = 1; i <= 12; i++) begin
         @(negedge clk);
         if (busy) busy_cnt++;
         if (done) begin
            done_cnt++;
            lat = i;
            start = 1'b0;
            break;
         end
         if (scramble) begin
            m = 4'($urandom_range(0, 15));
            q = 4'($urandom_range(0, 15));
            start = 1'($urandom_range(0, 1));
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      total++; if (result !== 8'h00) begin bad++; $display("FAIL reset_result got=%h exp=00", result); end
      total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
      rst = 1'b0;
   endtask

   task automatic test_basic();
      int lat, bc, dc;
      logic [7:0] e;
      @(negedge clk);
      run_op(4'b1001, 4'd3, 1'b0, lat, bc, dc);
      e = sb.pop_front();
      total++; if (result !== e || e !== 8'hEB) begin bad++; $display("FAIL basic_result got=%h exp=%h", result, e); end
      total++; if (lat !== 5) begin bad++; $display("FAIL basic_latency got=%0d exp=5", lat); end
      total++; if (bc !== 4) begin bad++; $display("FAIL basic_busy_cycles got=%0d exp=4", bc); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_busy_at_done got=%b exp=0", busy); end
      @(negedge clk);
      total++; if (done !== 1'b0) begin bad++; $display("FAIL basic_done_single got=%b exp=0", done); end
      total++; if (result !== e) begin bad++; $display("FAIL basic_result_hold got=%h exp=%h", result, e); end
   endtask

   task automatic test_back_to_back();
      logic [3:0] ma[3] = '{4'd4, 4'b1011, 4'b1100};
      logic [3:0] qa[3] = '{4'd2, 4'b1110, 4'b1110};
      logic [7:0] ref_vals[3] = '{8'h08, 8'h0A, 8'h08};
      int lat, bc, dc;
      logic [7:0] e;
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         run_op(ma[i], qa[i], 1'b0, lat, bc, dc);
         e = sb.pop_front();
         total++; if (result !== e || e !== ref_vals[i]) begin bad++; $display("FAIL b2b_result[%0d] got=%h exp=%h", i, result, e); end
         total++; if (lat !== 5) begin bad++; $display("FAIL b2b_latency[%0d] got=%0d exp=5", i, lat); end
      end
      @(negedge clk);
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b_idle_busy got=%b exp=0", busy); end
   endtask

   task automatic test_corners();
      logic [3:0] ma[5] = '{4'b1000, 4'b1000, 4'd7, 4'd0, 4'b1111};
      logic [3:0] qa[5] = '{4'b1000, 4'd7, 4'b1000, 4'b1111, 4'b1111};
      logic [7:0] ref_vals[5] = '{8'h40, 8'hC8, 8'hC8, 8'h00, 8'h01};
      int lat, bc, dc;
      logic [7:0] e;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         run_op(ma[i], qa[i], 1'b0, lat, bc, dc);
         e = sb.pop_front();
         total++; if (result !== e || e !== ref_vals[i]) begin bad++; $display("FAIL corner_result[%0d] got=%h exp=%h", i, result, e); end
         total++; if (lat !== 5) begin bad++; $display("FAIL corner_latency[%0d] got=%0d exp=5", i, lat); end
      end
   endtask

   task automatic test_input_changes();
      int lat, bc, dc, extra;
      logic [7:0] e;
      @(negedge clk);
      run_op(4'd6, 4'b1101, 1'b1, lat, bc, dc);
      e = sb.pop_front();
      total++; if (result !== e || e !== 8'hEE) begin bad++; $display("FAIL scramble_result got=%h exp=%h", result, e); end
      total++; if (lat !== 5) begin bad++; $display("FAIL scramble_latency got=%0d exp=5", lat); end
      extra = 0;
      repeat (6) begin
         @(negedge clk);
         if (done) extra++;
      end
      total++; if (extra !== 0) begin bad++; $display("FAIL scramble_extra_done got=%0d exp=0", extra); end
   endtask

   task automatic test_reset_mid_run();
      int lat, bc, dc, seen;
      logic [7:0] e;
      @(negedge clk);
      start = 1'b1;
      m = 4'd5;
      q = 4'b1101;
      @(posedge clk);
      #1;
      start = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b exp=0", busy); end
      total++; if (done !== 1'b0) begin bad++; $display("FAIL abort_done got=%b exp=0", done); end
      total++; if (result !== 8'h00) begin bad++; $display("FAIL abort_result got=%h exp=00", result); end
      seen = 0;
      repeat (6) begin
         @(negedge clk);
         if (done) seen++;
      end
      total++; if (seen !== 0) begin bad++; $display("FAIL abort_late_done got=%0d exp=0", seen); end
      run_op(4'd3, 4'd3, 1'b0, lat, bc, dc);
      e = sb.pop_front();
      total++; if (result !== e || e !== 8'h09) begin bad++; $display("FAIL after_abort_result got=%h exp=%h", result, e); end
      total++; if (lat !== 5) begin bad++; $display("FAIL after_abort_latency got=%0d exp=5", lat); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_back_to_back();
      test_corners();
      test_input_changes();
      test_reset_mid_run();
      total++; if (sb.size() !== 0) begin bad++; $display("FAIL scoreboard_leftover got=%0d exp=0", sb.size()); end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
